// File: rtl/consumer_pkg.sv
// consumer_pkg: shared lane state encoding, LFSR constants and counter limit
// for the consumer_fsm sink/checker.
`default_nettype none
`timescale 1ns/1ps

package consumer_pkg;

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } lane_state_t;

    localparam logic [15:0] LFSR_TAPS  = 16'hB400;  // taps 16,14,13,11
    localparam logic [15:0] SEED_LANE1 = 16'hACE1;
    localparam logic [15:0] SEED_LANE2 = 16'h1D2B;

    localparam int          CNT_W_DEFAULT = 16;
    localparam logic [15:0] CNT_MAX       = {CNT_W_DEFAULT{1'b1}};

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/consumer_lane.sv
// consumer_lane: one lane of stall generation, +1 sequence checking and
// saturating counters. Optional LFSR stall via CONSUMER_LFSR_STALL_EN.
`default_nettype none
`timescale 1ns/1ps

module consumer_lane
    import consumer_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 16,
    parameter int STALL_PERIOD = 4
`ifdef CONSUMER_LFSR_STALL_EN
    ,
    parameter logic [15:0] SEED = SEED_LANE1
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_mismatch,
    output logic [CNT_W-1:0]  o_recv_count,
    output logic [CNT_W-1:0]  o_err_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    lane_state_t       r_state;
    lane_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_expected;
    logic [CNT_W-1:0]  r_recv;
    logic [CNT_W-1:0]  r_err;
    logic              w_stall;
    logic              w_accept;
    logic              w_mismatch;

    generate
        if (STALL_PERIOD == 0) begin : g_stall_off
            assign w_stall = 1'b0;
        end else begin : g_stall_on
            logic r_stall;
`ifdef CONSUMER_LFSR_STALL_EN
            logic [15:0] r_lfsr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lfsr  <= SEED;
                    r_stall <= 1'b0;
                end else begin
                    r_lfsr  <= lfsr_next(r_lfsr);
                    r_stall <= (r_lfsr[1:0] == 2'b00);
                end
            end
`else
            localparam int               c_PH_W    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
            localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(STALL_PERIOD - 1);
            logic [c_PH_W-1:0] r_phase;

            // Stall is raised in the cycle following the last phase value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_phase <= '0;
                    r_stall <= 1'b0;
                end else begin
                    r_stall <= (r_phase == c_PH_LAST);
                    r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + 1'b1;
                end
            end
`endif
            assign w_stall = r_stall;
        end
    endgenerate

    assign w_accept   = i_valid && !i_flush && !w_stall;
    assign w_mismatch = w_accept && (r_state == CHECK) && (i_data != r_expected);

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = SYNC;
        end else if (w_accept) begin
            w_state_nxt = CHECK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Match and resync both leave expected at data+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expected <= '0;
            r_recv     <= '0;
            r_err      <= '0;
        end else if (w_accept) begin
            r_expected <= i_data + 1'b1;
            if (r_recv != c_CNT_MAX) begin
                r_recv <= r_recv + 1'b1;
            end
            if (w_mismatch && (r_err != c_CNT_MAX)) begin
                r_err <= r_err + 1'b1;
            end
        end
    end

    assign o_stall      = w_stall;
    assign o_mismatch   = w_mismatch;
    assign o_recv_count = r_recv;
    assign o_err_count  = r_err;

endmodule

`default_nettype wire

// File: rtl/consumer_fsm.sv
// consumer_fsm: two independent consumer lanes plus a sticky error flag.
// Optional LFSR-based stall enabled by defining CONSUMER_LFSR_STALL_EN.
`default_nettype none
`timescale 1ns/1ps

module consumer_fsm
    import consumer_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int STALL_PERIOD_1 = 4,
    parameter int STALL_PERIOD_2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_1,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic              in_flush_1,
    input  logic              in_valid_2,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic              in_flush_2,
    output logic              out_stall_1,
    output logic              out_stall_2,
    output logic [CNT_W-1:0]  out_recv_count_1,
    output logic [CNT_W-1:0]  out_recv_count_2,
    output logic [CNT_W-1:0]  out_err_count_1,
    output logic [CNT_W-1:0]  out_err_count_2,
    output logic              out_error
);

    logic w_mismatch_1;
    logic w_mismatch_2;
    logic r_error;

    consumer_lane #(
        .DATA_W       (DATA_W),
        .CNT_W        (CNT_W),
        .STALL_PERIOD (STALL_PERIOD_1)
`ifdef CONSUMER_LFSR_STALL_EN
        ,
        .SEED         (SEED_LANE1)
`endif
    ) u_lane_1 (
        .clk          (clk),
        .rst          (reset),
        .i_valid      (in_valid_1),
        .i_data       (in_data_1),
        .i_flush      (in_flush_1),
        .o_stall      (out_stall_1),
        .o_mismatch   (w_mismatch_1),
        .o_recv_count (out_recv_count_1),
        .o_err_count  (out_err_count_1)
    );

    consumer_lane #(
        .DATA_W       (DATA_W),
        .CNT_W        (CNT_W),
        .STALL_PERIOD (STALL_PERIOD_2)
`ifdef CONSUMER_LFSR_STALL_EN
        ,
        .SEED         (SEED_LANE2)
`endif
    ) u_lane_2 (
        .clk          (clk),
        .rst          (reset),
        .i_valid      (in_valid_2),
        .i_data       (in_data_2),
        .i_flush      (in_flush_2),
        .o_stall      (out_stall_2),
        .o_mismatch   (w_mismatch_2),
        .o_recv_count (out_recv_count_2),
        .o_err_count  (out_err_count_2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_mismatch_1 || w_mismatch_2) begin
            r_error <= 1'b1;
        end
    end

    assign out_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_consumer_fsm.sv
// tb_consumer_fsm: directed and randomized checks of consumer_fsm against a
// transaction-level reference model of the two lanes.
`default_nettype none
`timescale 1ns/1ps

module tb_consumer_fsm;

    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int P1   = 4;
    localparam int P2   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid_1 = 1'b0, in_flush_1 = 1'b0;
    logic          in_valid_2 = 1'b0, in_flush_2 = 1'b0;
    logic [DW-1:0] in_data_1 = '0, in_data_2 = '0;
    logic          out_stall_1, out_stall_2, out_error;
    logic [CW-1:0] out_recv_count_1, out_recv_count_2;
    logic [CW-1:0] out_err_count_1, out_err_count_2;

    consumer_fsm #(
        .DATA_W(DW), .CNT_W(CW), .STALL_PERIOD_1(P1), .STALL_PERIOD_2(P2)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid_1(in_valid_1), .in_data_1(in_data_1), .in_flush_1(in_flush_1),
        .in_valid_2(in_valid_2), .in_data_2(in_data_2), .in_flush_2(in_flush_2),
        .out_stall_1(out_stall_1), .out_stall_2(out_stall_2),
        .out_recv_count_1(out_recv_count_1), .out_recv_count_2(out_recv_count_2),
        .out_err_count_1(out_err_count_1), .out_err_count_2(out_err_count_2),
        .out_error(out_error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: edges since reset, "synchronised" flag, next expected value.
    int            per[2] = '{P1, P2};
    int            m_n;
    bit            m_have[2];
    logic [DW-1:0] m_exp[2];
    int            m_recv[2];
    int            m_err[2];
    bit            m_error;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    bit            drv_v[2];
    bit            drv_f[2];
    logic [DW-1:0] drv_d[2];
    bit            acc[2];
    bit            held[2];
    logic [DW-1:0] s0, s1, dtmp;

    function automatic bit m_stall(input int l);
        return (per[l] != 0) && (m_n != 0) && ((m_n % per[l]) == 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stall_1", 64'(out_stall_1), 64'(m_stall(0)));
        chk("stall_2", 64'(out_stall_2), 64'(m_stall(1)));
        chk("recv_1", 64'(out_recv_count_1), 64'(m_recv[0]));
        chk("recv_2", 64'(out_recv_count_2), 64'(m_recv[1]));
        chk("err_1", 64'(out_err_count_1), 64'(m_err[0]));
        chk("err_2", 64'(out_err_count_2), 64'(m_err[1]));
        chk("error", 64'(out_error), 64'(m_error));
    endtask

    task automatic model_reset();
        m_n = 0;
        for (int l = 0; l < 2; l++) begin
            m_have[l] = 1'b0;
            m_exp[l]  = '0;
            m_recv[l] = 0;
            m_err[l]  = 0;
            held[l]   = 1'b0;
        end
        m_error = 1'b0;
    endtask

    // One clock: drive prepared inputs, advance model, check outputs.
    task automatic tick();
        bit st;
        in_valid_1 = drv_v[0]; in_data_1 = drv_d[0]; in_flush_1 = drv_f[0];
        in_valid_2 = drv_v[1]; in_data_2 = drv_d[1]; in_flush_2 = drv_f[1];
        @(posedge clk);
        for (int l = 0; l < 2; l++) begin
            st     = m_stall(l);
            acc[l] = 1'b0;
            if (drv_f[l]) begin
                m_have[l] = 1'b0;
            end else if (drv_v[l] && !st) begin
                if (m_have[l] && (drv_d[l] != m_exp[l])) begin
                    if (m_err[l] < CMAX) m_err[l]++;
                    m_error = 1'b1;
                end
                if (m_recv[l] < CMAX) m_recv[l]++;
                m_have[l] = 1'b1;
                m_exp[l]  = drv_d[l] + 1'b1;
                acc[l]    = 1'b1;
            end
            held[l] = drv_v[l] && !drv_f[l] && !acc[l];
        end
        m_n++;
        #1;
        check_all();
    endtask

    task automatic cycle(input bit allow_gap, input bit fl0, input bit fl1);
        drv_v[0] = (q0.size() != 0) && (held[0] || !allow_gap || ($urandom_range(4, 0) != 0));
        drv_d[0] = (q0.size() != 0) ? q0[0] : DW'($urandom());
        drv_v[1] = (q1.size() != 0) && (held[1] || !allow_gap || ($urandom_range(4, 0) != 0));
        drv_d[1] = (q1.size() != 0) ? q1[0] : DW'($urandom());
        drv_f[0] = fl0;
        drv_f[1] = fl1;
        tick();
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (q0.size() != 0 || q1.size() != 0); i++) begin
            cycle(1'b0, 1'b0, 1'b0);
        end
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        #3 reset = 1'b1;
        #1;
        chk("rst_stall_1", 64'(out_stall_1), 64'd0);
        chk("rst_stall_2", 64'(out_stall_2), 64'd0);
        chk("rst_recv_1", 64'(out_recv_count_1), 64'd0);
        chk("rst_recv_2", 64'(out_recv_count_2), 64'd0);
        chk("rst_err_1", 64'(out_err_count_1), 64'd0);
        chk("rst_err_2", 64'(out_err_count_2), 64'd0);
        chk("rst_error", 64'(out_error), 64'd0);
        q0.delete();
        q1.delete();
        in_valid_1 = 1'b0; in_flush_1 = 1'b0;
        in_valid_2 = 1'b0; in_flush_2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Clean sequence on lane 1, one gap on lane 2.
        q0 = '{32'd5, 32'd6, 32'd7, 32'd8};
        q1 = '{32'd10, 32'd11, 32'd13, 32'd14};
        drain(40);
        chk("t1_recv_1", 64'(out_recv_count_1), 64'd4);
        chk("t1_err_1", 64'(out_err_count_1), 64'd0);
        chk("t2_recv_2", 64'(out_recv_count_2), 64'd4);
        chk("t2_err_2", 64'(out_err_count_2), 64'd1);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        chk("t2_error_sticky", 64'(out_error), 64'd1);

        // Flush with a valid matching beat: discarded, lane resyncs on 100.
        q0.push_back(32'd9);
        cycle(1'b0, 1'b1, 1'b0);
        void'(q0.pop_front());
        q0.push_back(32'd100);
        q0.push_back(32'd101);
        drain(20);
        chk("t4_recv_1", 64'(out_recv_count_1), 64'd6);
        chk("t4_err_1", 64'(out_err_count_1), 64'd0);

        // Mid-stream reset, then first beats resync cleanly.
        do_reset();
        q0.push_back(32'd50);
        q1.push_back(32'd77);
        drain(20);
        chk("t6_recv_1", 64'(out_recv_count_1), 64'd1);
        chk("t6_err_2", 64'(out_err_count_2), 64'd0);
        chk("t6_error", 64'(out_error), 64'd0);

        // Randomized traffic: gaps, sequence jumps, flushes, data wrap.
        s0 = 32'hFFFF_FFF0;
        s1 = DW'($urandom());
        for (int i = 0; i < 300; i++) begin
            if (q0.size() == 0) begin
                dtmp = ($urandom_range(7, 0) == 0) ? s0 + DW'($urandom_range(50, 2)) : s0;
                q0.push_back(dtmp);
                s0 = dtmp + 1'b1;
            end
            if (q1.size() == 0) begin
                dtmp = ($urandom_range(7, 0) == 0) ? s1 + DW'($urandom_range(50, 2)) : s1;
                q1.push_back(dtmp);
                s1 = dtmp + 1'b1;
            end
            cycle(1'b1, ($urandom_range(29, 0) == 0), ($urandom_range(29, 0) == 0));
        end

        // Saturation: lane 1 good beats, lane 2 every beat mismatched.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            q0.push_back(DW'(1000 + i));
            q1.push_back(DW'(3 * i));
        end
        drain(1000);
        chk("t5_recv_1_sat", 64'(out_recv_count_1), 64'(CMAX));
        chk("t5_err_2_sat", 64'(out_err_count_2), 64'(CMAX));
        chk("t5_err_1", 64'(out_err_count_1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
